// File: rtl/sha256_varlen.sv
// Variable-length SHA-256: reads num_words message words, pads on the fly,
// compresses block by block with a 16-entry rolling schedule window, writes the digest.
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | fetch 16 padded words of the current block (17 cycles)
//   ROUND  | 64 compression rounds
//   UPDATE | fold working vars into H, advance block
//   WRITE  | write H0..H7 to output_addr
//   DONE   | one-cycle done (and error on rejection)
module sha256_varlen #(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       num_words,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ROUND, S_UPDATE, S_WRITE, S_DONE
  } state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t            state_q, state_d;
  logic [6:0]        cnt_q;
  logic [15:0]       blk_q, last_blk_q, n_q;
  logic [ADDR_W-1:0] msg_q, out_q;
  logic              err_q;
  logic [31:0]       h_q [8];
  logic [31:0]       v_q [8];
  logic [31:0]       w_q [16];

  logic        reject;
  logic [3:0]  cap_idx;
  logic [19:0] g_rd, g_cap;
  logic [31:0] pad_word, cap_word, w_new, w_r, t1, t2;

  assign reject  = num_words > 16'(MAX_WORDS);
  assign cap_idx = cnt_q[3:0] - 4'd1;
  assign g_rd    = {blk_q, cnt_q[3:0]};
  assign g_cap   = {blk_q, cap_idx};

  // Words past the message are synthesised; memory contents there are ignored.
  always_comb begin
    pad_word = 32'h0;
    if (g_cap == {4'd0, n_q})
      pad_word = 32'h8000_0000;
    else if (g_cap == {last_blk_q, 4'hF})
      pad_word = {11'd0, n_q, 5'd0};
  end

  assign cap_word = (g_cap < {4'd0, n_q}) ? mem_read_data : pad_word;

  // Window holds W[r-16..r-1] in w_q[0..15] once r >= 16.
  assign w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
  assign w_r   = (cnt_q[6:4] == 3'd0) ? w_q[cnt_q[3:0]] : w_new;
  assign t1    = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
               + K[cnt_q[5:0]] + w_r;
  assign t2    = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = reject ? S_DONE : S_LOAD;
      S_LOAD:   if (cnt_q == 7'd16) state_d = S_ROUND;
      S_ROUND:  if (cnt_q == 7'd63) state_d = S_UPDATE;
      S_UPDATE: state_d = (blk_q == last_blk_q) ? S_WRITE : S_LOAD;
      S_WRITE:  if (cnt_q == 7'd7) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 7'd0;
      blk_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_d != state_q || state_q == S_IDLE) ? 7'd0 : cnt_q + 7'd1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_q <= reject;
            if (!reject) begin
              n_q        <= num_words;
              msg_q      <= message_addr;
              out_q      <= output_addr;
              blk_q      <= 16'd0;
              last_blk_q <= 16'((17'(num_words) + 17'd2) >> 4);
              for (int i = 0; i < 8; i++) h_q[i] <= IV[i];
            end
          end
        end
        S_LOAD: begin
          if (cnt_q != 7'd0) w_q[cap_idx] <= cap_word;
          if (cnt_q == 7'd16)
            for (int i = 0; i < 8; i++) v_q[i] <= h_q[i];
        end
        S_ROUND: begin
          v_q[0] <= t1 + t2;
          v_q[1] <= v_q[0];
          v_q[2] <= v_q[1];
          v_q[3] <= v_q[2];
          v_q[4] <= v_q[3] + t1;
          v_q[5] <= v_q[4];
          v_q[6] <= v_q[5];
          v_q[7] <= v_q[6];
          if (cnt_q[6:4] != 3'd0) begin
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
            w_q[15] <= w_new;
          end
        end
        S_UPDATE: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
          blk_q <= blk_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_clk = clk;
  assign busy    = (state_q == S_LOAD) || (state_q == S_ROUND) ||
                   (state_q == S_UPDATE) || (state_q == S_WRITE);
  assign done    = (state_q == S_DONE);
  assign error   = (state_q == S_DONE) && err_q;
  // Gated by reset so a reset landing in WRITE cannot commit one more word.
  assign mem_we  = (state_q == S_WRITE) && !reset;

  always_comb begin
    mem_addr       = '0;
    mem_write_data = 32'h0;
    if (state_q == S_LOAD && cnt_q[6:4] == 3'd0) begin
      mem_addr = msg_q + ADDR_W'(g_rd);
    end else if (state_q == S_WRITE) begin
      mem_addr       = out_q + ADDR_W'(cnt_q[2:0]);
      mem_write_data = h_q[cnt_q[2:0]];
    end
  end

endmodule

// File: tb/tb_sha256_varlen.sv
// Bench for sha256_varlen: memory model, software SHA-256 reference and a
// scoreboard of expected digests/latencies compared when done pulses.
module tb_sha256_varlen;
  localparam int MAX_WORDS = 64;
  localparam int ADDR_W    = 16;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] ABCD_DIG  = 256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;

  logic clk = 1'b0;
  logic reset, start;
  logic [15:0] num_words, message_addr, output_addr;
  logic busy, done, error, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic tb_we;
  logic [15:0] tb_addr;
  logic [31:0] tb_data;

  sha256_varlen #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .message_addr(message_addr), .output_addr(output_addr),
    .busy(busy), .done(done), .error(error), .mem_clk(mem_clk),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    mem_read_data <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_write_data;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  // Reference SHA-256 over whole 32-bit words, full 64-entry schedule.
  function automatic logic [255:0] sha_ref(input logic [31:0] msg [$]);
    logic [31:0] p [$];
    logic [31:0] h [8];
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, s0, s1, tt1, tt2;
    int len;
    len = msg.size();
    p = msg;
    p.push_back(32'h8000_0000);
    while (p.size() % 16 != 14) p.push_back(32'h0);
    p.push_back(32'h0);
    p.push_back(32'(len * 32));
    h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int bk = 0; bk < p.size() / 16; bk++) begin
      for (int i = 0; i < 64; i++) begin
        if (i < 16) w[i] = p[bk*16 + i];
        else begin
          s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
          s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
          w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int i = 0; i < 64; i++) begin
        s1  = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
        tt1 = hh + s1 + ((e & f) ^ (~e & g)) + KT[i] + w[i];
        s0  = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
        tt2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + tt1; d = c; c = b; b = a; a = tt1 + tt2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d;
      h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  typedef struct {
    logic [255:0] dig;
    logic [15:0]  msg;
    logic [15:0]  outa;
    int           n;
    bit           err;
    int           lat;
  } exp_t;
  exp_t sb [$];

  bit op_active = 0, op_done = 0, busy_seen = 0;
  int op_start = 0, writes = 0, first_wr = -1, addr_bad = 0;
  int dones_total = 0, wr_total = 0, exp_dones = 0;

  always @(negedge clk) begin : mon
    int lat, nb, j, t;
    exp_t e;
    logic [255:0] dg;
    if (mem_we) wr_total++;
    if (done) dones_total++;
    if (op_active && sb.size() > 0) begin
      lat = cyc - op_start;
      if (mem_we) begin
        writes++;
        if (first_wr < 0) first_wr = lat;
      end
      if (busy) busy_seen = 1;
      if (!sb[0].err) begin
        nb = (sb[0].lat - 9) / 82;
        j  = (lat - 1) / 82;
        t  = (lat - 1) % 82;
        if (lat >= 1 && j < nb && t < 16)
          if (mem_we || mem_addr !== sb[0].msg + 16'(16*j + t)) addr_bad++;
      end
      if (done) begin
        e = sb.pop_front();
        chk($sformatf("latency n=%0d", e.n), lat, e.lat);
        chk($sformatf("error n=%0d", e.n), error, e.err);
        chk($sformatf("busy_at_done n=%0d", e.n), busy, 0);
        if (e.err) begin
          chk("rej_writes", writes, 0);
          chk("rej_busy", busy_seen, 0);
        end else begin
          chk($sformatf("write_count n=%0d", e.n), writes, 8);
          chk($sformatf("first_write n=%0d", e.n), first_wr, e.lat - 8);
          chk($sformatf("read_addr_seq n=%0d", e.n), addr_bad, 0);
          for (int k = 0; k < 8; k++) dg[255 - 32*k -: 32] = mem[16'(e.outa + k)];
          chk($sformatf("digest n=%0d", e.n), dg, e.dig);
        end
        op_active = 0;
        op_done   = 1;
      end
    end
  end

  task automatic poke(input logic [15:0] a, input logic [31:0] d);
    tb_we = 1; tb_addr = a; tb_data = d;
    @(posedge clk); #1;
    tb_we = 0;
  endtask

  task automatic run_op(input int n, input logic [15:0] msg, input logic [15:0] outa,
                        input bit use_k, input logic [255:0] kdig, input logic [31:0] w0,
                        input int extra_at, input int abort_at);
    logic [31:0] words [$];
    exp_t e;
    int np;
    e.err = (n > MAX_WORDS);
    e.dig = '0;
    e.lat = 1;
    if (!e.err) begin
      for (int i = 0; i < n; i++) words.push_back((i == 0 && use_k) ? w0 : $urandom());
      // junk beyond the message: padding must not come from memory
      for (int i = 0; i < n + 18; i++) poke(16'(msg + i), (i < n) ? words[i] : $urandom());
      np = n + 1;
      while (np % 16 != 14) np++;
      np += 2;
      e.lat = 82 * (np / 16) + 9;
      e.dig = use_k ? kdig : sha_ref(words);
    end
    e.n = n; e.msg = msg; e.outa = outa;
    sb.push_back(e);
    num_words = 16'(n); message_addr = msg; output_addr = outa;
    op_start = cyc; writes = 0; first_wr = -1; addr_bad = 0; busy_seen = 0;
    op_done = 0; op_active = 1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 1; i < 2000 && !op_done; i++) begin
      if (abort_at != 0 && i == abort_at) begin
        reset = 1;
        op_active = 0;
        sb.delete();
        return;
      end
      start = (i == extra_at);
      @(posedge clk); #1;
    end
    start = 0;
    exp_dones++;
    chk($sformatf("done_seen n=%0d", n), op_done, 1);
    if (!op_done) begin
      op_active = 0;
      sb.delete();
    end
  endtask

  int wr_snap, dn_snap;

  initial begin
    reset = 1; start = 0; num_words = 0; message_addr = 0; output_addr = 0;
    tb_we = 0; tb_addr = 0; tb_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {busy, done, error, mem_we, mem_addr, mem_write_data}, 0);
    @(posedge clk); #1;
    reset = 0;

    run_op(0, 16'h0100, 16'h2000, 1, EMPTY_DIG, 32'h0, 0, 0);
    run_op(1, 16'h0200, 16'h2100, 1, ABCD_DIG, 32'h61626364, 0, 0);
    run_op(13, 16'h0300, 16'h2200, 0, '0, 32'h0, 0, 0);
    run_op(14, 16'h0400, 16'h2300, 0, '0, 32'h0, 0, 0);
    run_op(20, 16'hFFF0, 16'h2400, 0, '0, 32'h0, 0, 0);
    run_op(MAX_WORDS, 16'h0500, 16'h2500, 0, '0, 32'h0, 0, 0);
    run_op(MAX_WORDS + 1, 16'h0600, 16'h2600, 0, '0, 32'h0, 0, 0);

    // reset lands in ROUND of block 0
    run_op(20, 16'h0700, 16'h2700, 0, '0, 32'h0, 0, 30);
    wr_snap = wr_total;
    dn_snap = dones_total;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid_outputs", {busy, done, error, mem_we, mem_addr, mem_write_data}, 0);
    @(posedge clk); #1;
    reset = 0;
    repeat (120) @(posedge clk);
    #1;
    chk("reset_no_writes", wr_total - wr_snap, 0);
    chk("reset_no_done", dones_total - dn_snap, 0);

    run_op(0, 16'h0800, 16'h2800, 1, EMPTY_DIG, 32'h0, 0, 0);
    run_op(1, 16'h0900, 16'h2900, 1, ABCD_DIG, 32'h61626364, 40, 0);
    repeat (200) @(posedge clk);
    #1;
    chk("done_total", dones_total, exp_dones);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_varlen.md
Name: sha256_varlen

Overview:
- Parametrised successor of the team's fixed-length SHA-256 block.
- Hashes a message of run-time length num_words (32-bit words, 0..MAX_WORDS) read from the shared testbench/dpsram port, then writes the 256-bit digest back to output_addr.
- Generates SHA-256 padding and the length field on the fly for any block count.
- Keeps a 16-entry rolling W window instead of a 64-entry schedule array, and adds busy, error and a one-cycle done pulse.

Parameters:
- MAX_WORDS, 64, largest accepted num_words; must be ≤ 2^16-1.
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  single clock; mem_clk is driven from it.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- num_words  in  16  message length in words; latched at start.
- message_addr  in  ADDR_W  first message word address; latched at start.
- output_addr  in  ADDR_W  digest base address; latched at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of operation.
- error  out  1  one-cycle pulse with done when the request is rejected.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_write_data  out  32  write data.
- mem_read_data  in  32  read data; valid the cycle after its address is presented (1-cycle latency).

Behaviour:
- Reset: state IDLE; busy=0, done=0, error=0, mem_we=0, mem_addr=0, mem_write_data=0. Reset wins over every other event, including mid-operation. No write occurs after reset is asserted. H registers are reloaded on the next start.
- Block count: B = ceil((n+3)/16), where n = latched num_words. n=0..13 gives B=1; n=14..29 gives B=2.
- Padded word g (0 ≤ g < 16B), with blk = g/16 and t = g%16:
  - g < n: mem[message_addr+g]
  - g == n: 32'h80000000
  - g == 16B-1: n*32 (32-bit)
  - g == 16B-2: 0
  - otherwise: 0
- IDLE:
  - start with n ≤ MAX_WORDS: latch inputs; load H0..H7 with the standard IV; blk=0; go to LOAD.
  - start with n > MAX_WORDS: go to DONE with error set; no memory access.
  - start outside IDLE is ignored.
- LOAD (17 cycles per block):
  - Cycles 0..15: present mem_addr = message_addr + blk*16 + t (mem_we=0), even for padding words.
  - Cycles 1..16: capture word t-1 into W[t-1]. The captured value is mem_read_data if g < n, otherwise the generated pad word.
  - On the last cycle, load a..h from H0..H7 and go to ROUND.
- ROUND (64 cycles, r=0..63):
  - One compression round per cycle.
  - W_r = W[r] for r < 16.
  - For r ≥ 16, W_r = σ1(W[r-2]) + W[r-7] + σ0(W[r-15]) + W[r-16] (mod 2^32), computed from the 16-entry shift window.
  - The window shifts each cycle from r ≥ 16.
  - All additions are mod 2^32, using the standard K[r], Σ0/Σ1/Ch/Maj.
- UPDATE (1 cycle): Hi <= Hi + working var, for i = 0..7. blk++. If blk == B-1, go to WRITE; otherwise go to LOAD.
- WRITE (8 cycles, k=0..7): mem_we=1, mem_addr = output_addr+k, mem_write_data = Hk. mem_we returns to 0 on exit.
- DONE (1 cycle): done=1; error=1 only on rejection; busy=0; go to IDLE.
- Latency: start sampled in cycle 0 gives done high in cycle 82B+9. B=1 gives 91; B=2 gives 173.
- busy is high from cycle 1 through cycle 82B+8.
- Rejected request: done and error high in cycle 1.
- start held high across done launches the next operation from IDLE on the following cycle.
- Address arithmetic wraps mod 2^ADDR_W.

Test Plan:
- n=0, any message_addr → digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855 at output_addr..+7; done at cycle 91; exactly 8 write cycles.
- n=1, word 0x61626364 ("abcd") → digest 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589.
- n=13 vs n=14, random data → match software SHA-256; done at cycle 91 and 173 respectively (1/2 block boundary).
- n=20 and n=MAX_WORDS, random data → match software model; no write before the WRITE phase; mem_addr read sequence is contiguous from message_addr.
- n=MAX_WORDS+1 → done and error both pulse at cycle 1; mem_we never high; busy stays 0.
- Reset asserted during ROUND of block 0 → next cycle all outputs at reset values, no writes. A subsequent start with n=0 yields the empty-message digest. A start pulse while busy is ignored: only one done is produced.
